// File: rtl/demod_pkg.sv
// ============================================================================
// Module  : demod_pkg
// Brief   : Shared state encoding and default constants for the QPSK sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demod_pkg;

    localparam int DATA_W              = 19;
    localparam int SPS_DEFAULT         = 8;
    localparam int LOCK_THRESH_DEFAULT = 2048;
    localparam int LOCK_COUNT_DEFAULT  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/demod_lock_detect.sv
// ============================================================================
// Module  : demod_lock_detect
// Brief   : Counts consecutive strong-amplitude symbols and flags constellation lock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demod_lock_detect
    import demod_pkg::*;
#(
    parameter int DATA_W      = demod_pkg::DATA_W,
    parameter int LOCK_THRESH = LOCK_THRESH_DEFAULT,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     strobe_i,
    input  logic signed [DATA_W-1:0] i_sample_i,
    input  logic signed [DATA_W-1:0] q_sample_i,
    output logic                     locked_o
);

    localparam int                c_cnt_w   = $clog2(LOCK_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(LOCK_COUNT);
    localparam logic [DATA_W-1:0]  c_thresh  = DATA_W'(LOCK_THRESH);

    // The most negative code has no positive twin, so it folds onto full scale.
    function automatic logic [DATA_W-2:0] sat_mag(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] neg;
        neg = -x;
        if (x[DATA_W-1] && (x[DATA_W-2:0] == '0)) begin
            sat_mag = '1;
        end else if (x[DATA_W-1]) begin
            sat_mag = neg[DATA_W-2:0];
        end else begin
            sat_mag = x[DATA_W-2:0];
        end
    endfunction

    logic [DATA_W-2:0]  w_mag_i;
    logic [DATA_W-2:0]  w_mag_q;
    logic               w_good;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               locked_q, locked_d;

    assign w_mag_i = sat_mag(i_sample_i);
    assign w_mag_q = sat_mag(q_sample_i);
    assign w_good  = ({1'b0, w_mag_i} >= c_thresh) && ({1'b0, w_mag_q} >= c_thresh);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (strobe_i) begin
            if (!w_good) begin
                cnt_d = '0;
            end else if (cnt_q != c_cnt_max) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        locked_d = (cnt_d == c_cnt_max);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o = locked_q;

endmodule

`default_nettype wire

// File: rtl/demod_sequencer.sv
// ============================================================================
// Module  : demod_sequencer
// Brief   : Flush/settle/run sequencer, symbol strobe and I-first bit slicer.
//           Lock detector compiled in when DEMOD_SEQ_LOCK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demod_sequencer
    import demod_pkg::*;
#(
    parameter int SPS           = SPS_DEFAULT,
    parameter int SETTLE_CYCLES = 32,
    parameter int FLUSH_CYCLES  = 4,
    parameter int DATA_W        = demod_pkg::DATA_W,
    parameter int LOCK_THRESH   = LOCK_THRESH_DEFAULT,
    parameter int LOCK_COUNT    = LOCK_COUNT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [$clog2(SPS)-1:0]   phase_sel,
    input  logic signed [DATA_W-1:0] I_filtered,
    input  logic signed [DATA_W-1:0] Q_filtered,
    output logic                     filt_en,
    output logic                     filt_clr,
    output logic                     sym_strobe,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic                     busy,
    output logic                     locked
);

    localparam int                 c_ph_w      = $clog2(SPS);
    localparam int                 c_tmr_max   = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
    localparam int                 c_tmr_w     = $clog2(c_tmr_max + 1);
    localparam logic [c_tmr_w-1:0] c_flush_ld  = c_tmr_w'(FLUSH_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_settle_ld = c_tmr_w'(SETTLE_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last   = c_ph_w'(SPS - 1);
    localparam logic [c_ph_w-1:0]  c_q_delay   = c_ph_w'(SPS / 2 - 1);

    state_t              state_q, state_d;
    logic [c_tmr_w-1:0]  tmr_q, tmr_d;
    logic [c_ph_w-1:0]   pcnt_q, pcnt_d;
    logic [c_ph_w-1:0]   phase_q, phase_d;
    logic                qpend_q, qpend_d;
    logic                qbit_q, qbit_d;
    logic [c_ph_w-1:0]   qcnt_q, qcnt_d;
    logic                filt_en_q, filt_en_d;
    logic                filt_clr_q, filt_clr_d;
    logic                strobe_q, strobe_d;
    logic                bit_out_q, bit_out_d;
    logic                bit_valid_q, bit_valid_d;
    logic                busy_q, busy_d;

    logic                w_take;
    logic                w_q_emit;
    logic                w_lock_clr;

    // strobe_q can only be high while in RUN; a simultaneous stop drops the symbol.
    assign w_take     = strobe_q && !stop;
    assign w_q_emit   = qpend_q && (qcnt_q == '0);
    assign w_lock_clr = (state_q != RUN) && (state_q != DRAIN);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        pcnt_d      = '0;
        phase_d     = phase_q;
        qpend_d     = qpend_q;
        qbit_d      = qbit_q;
        qcnt_d      = qcnt_q;
        strobe_d    = 1'b0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        filt_en_d   = (state_q != IDLE);
        filt_clr_d  = (state_q == FLUSH);
        busy_d      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = FLUSH;
                    tmr_d   = c_flush_ld;
                    phase_d = phase_sel;
                end
            end
            FLUSH: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d = SETTLE;
                    tmr_d   = c_settle_ld;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RUN: begin
                pcnt_d = (pcnt_q == c_ph_last) ? '0 : pcnt_q + 1'b1;
                if (stop) begin
                    state_d = (qpend_q && !w_q_emit) ? DRAIN : IDLE;
                end else begin
                    strobe_d = (pcnt_q == phase_q);
                end
            end
            DRAIN: begin
                if (w_q_emit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (qpend_q && ((state_q == RUN) || (state_q == DRAIN))) begin
            if (w_q_emit) begin
                bit_valid_d = 1'b1;
                bit_out_d   = qbit_q;
                qpend_d     = 1'b0;
            end else begin
                qcnt_d = qcnt_q - 1'b1;
            end
        end

        if (w_take) begin
            bit_valid_d = 1'b1;
            bit_out_d   = !I_filtered[DATA_W-1];
            qpend_d     = 1'b1;
            qbit_d      = !Q_filtered[DATA_W-1];
            qcnt_d      = c_q_delay;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            pcnt_q      <= '0;
            phase_q     <= '0;
            qpend_q     <= 1'b0;
            qbit_q      <= 1'b0;
            qcnt_q      <= '0;
            filt_en_q   <= 1'b0;
            filt_clr_q  <= 1'b0;
            strobe_q    <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            pcnt_q      <= pcnt_d;
            phase_q     <= phase_d;
            qpend_q     <= qpend_d;
            qbit_q      <= qbit_d;
            qcnt_q      <= qcnt_d;
            filt_en_q   <= filt_en_d;
            filt_clr_q  <= filt_clr_d;
            strobe_q    <= strobe_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign filt_en    = filt_en_q;
    assign filt_clr   = filt_clr_q;
    assign sym_strobe = strobe_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;

`ifdef DEMOD_SEQ_LOCK_EN
    demod_lock_detect #(
        .DATA_W      (DATA_W),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_COUNT  (LOCK_COUNT)
    ) u_lock (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (w_lock_clr),
        .strobe_i   (w_take),
        .i_sample_i (I_filtered),
        .q_sample_i (Q_filtered),
        .locked_o   (locked)
    );
`else
    logic w_unused_lock;
    assign w_unused_lock = ^{I_filtered[DATA_W-2:0], Q_filtered[DATA_W-2:0], w_lock_clr,
                             (LOCK_THRESH != 0), (LOCK_COUNT != 0)};
    assign locked        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demod_sequencer.sv
// ============================================================================
// Module  : tb_demod_sequencer
// Brief   : Self-checking bench: symbol table with bit scoreboard plus corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demod_sequencer;

    localparam int SPS   = 8;
    localparam int DW    = 19;
    localparam int N_VEC = 37;
    localparam int RUN_FIRST = 1 + 4 + 32;
    localparam logic signed [DW-1:0] MIN_CODE = {1'b1, {(DW-1){1'b0}}};

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic [2:0]           phase_sel = '0;
    logic signed [DW-1:0] I_filtered = '0;
    logic signed [DW-1:0] Q_filtered = '0;
    logic                 filt_en, filt_clr, sym_strobe, bit_out, bit_valid, busy, locked;

    demod_sequencer #(
        .SPS           (SPS),
        .SETTLE_CYCLES (32),
        .FLUSH_CYCLES  (4),
        .DATA_W        (DW),
        .LOCK_THRESH   (2048),
        .LOCK_COUNT    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .phase_sel  (phase_sel),
        .I_filtered (I_filtered),
        .Q_filtered (Q_filtered),
        .filt_en    (filt_en),
        .filt_clr   (filt_clr),
        .sym_strobe (sym_strobe),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic val;
    } sb_t;

    typedef struct {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        logic                 ei;
        logic                 eq;
        logic                 el;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[N_VEC];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   c        = 0;
    bit   m_active = 1'b0;
    int   m_phase  = 0;
    int   m_strobe_end = 0;
    bit   prev_strobe = 1'b0;
    logic cur_ei = 1'b0;
    logic cur_eq = 1'b0;
    logic cur_el = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
        end
    endtask

    function automatic bit model_strobe(input int cc);
        return m_active && (cc >= RUN_FIRST) && (cc < m_strobe_end)
               && (((cc - RUN_FIRST) % SPS) == m_phase);
    endfunction

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        c++;
        if (prev_strobe) begin
            e.cyc = c;           e.val = cur_ei; sb.push_back(e);
            e.cyc = c + SPS / 2; e.val = cur_eq; sb.push_back(e);
`ifdef DEMOD_SEQ_LOCK_EN
            check("locked", locked, cur_el);
`else
            check("locked", locked, 0);
`endif
        end
        if (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            check("bit_valid", bit_valid, 1);
            check("bit_out", bit_out, e.val);
        end else begin
            check("bit_valid_idle", bit_valid, 0);
        end
        check("sym_strobe", sym_strobe, model_strobe(c));
        prev_strobe = model_strobe(c);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".filt_en"},    filt_en, 0);
        check({tag, ".filt_clr"},   filt_clr, 0);
        check({tag, ".sym_strobe"}, sym_strobe, 0);
        check({tag, ".bit_out"},    bit_out, 0);
        check({tag, ".bit_valid"},  bit_valid, 0);
        check({tag, ".busy"},       busy, 0);
        check({tag, ".locked"},     locked, 0);
    endtask

    task automatic do_reset();
        sb.delete();
        m_active    = 1'b0;
        prev_strobe = 1'b0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        I_filtered = '0; Q_filtered = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_at(input int ph);
        phase_sel    = 3'(ph);
        start        = 1'b1;
        c            = -1;
        m_phase      = ph;
        m_strobe_end = 1 << 30;
        m_active     = 1'b1;
        tick();
        start     = 1'b0;
        phase_sel = ~3'(ph);
    endtask

    initial begin
        int idx;
        int t_last;

        for (int k = 0; k < N_VEC; k++) begin
            int g;
            g = (k < 16) ? k : k - 19;
            tbl[k].i  = (g % 2 != 0) ? DW'(3000) : DW'(-3000);
            tbl[k].q  = (g % 3 == 0) ? DW'(-3000) : DW'(3000 + g);
            tbl[k].ei = (g % 2 != 0);
            tbl[k].eq = (g % 3 != 0);
            tbl[k].el = (k == 15) || (k == 34);
        end
        tbl[16] = '{DW'(100),   DW'(3000),  1'b1, 1'b1, 1'b0};
        tbl[17] = '{DW'(2048),  DW'(-2048), 1'b1, 1'b0, 1'b0};
        tbl[18] = '{DW'(2047),  DW'(3000),  1'b1, 1'b1, 1'b0};
        tbl[34] = '{MIN_CODE,   MIN_CODE,   1'b0, 1'b0, 1'b1};
        tbl[35] = '{DW'(5000),  MIN_CODE,   1'b1, 1'b0, 1'b1};
        tbl[36] = '{DW'(0),     DW'(-1),    1'b1, 1'b0, 1'b0};

        do_reset();
        check_idle("reset");

        // Reference timeline: phase 3, one symbol, stop while the Q bit is pending.
        I_filtered = DW'(500); Q_filtered = DW'(-500);
        cur_ei = 1'b1; cur_eq = 1'b0; cur_el = 1'b0;
        start_at(3);
        m_strobe_end = 43;
        while (c < 60) begin
            tick();
            if (c >= 1 && c <= 5) check("filt_clr", filt_clr, (c <= 4));
            if (c == 20) check("filt_en_settle", filt_en, 1);
            if (c == 37) check("busy_run", busy, 1);
            if (c == 42) stop = 1'b1;
            if (c == 43) stop = 1'b0;
            if (c == 45) check("busy_drain", busy, 1);
            if (c == 46) begin
                check("busy_idle", busy, 0);
                check("filt_en_idle", filt_en, 0);
            end
        end
        check("sb_empty_drain", sb.size(), 0);

        do_reset();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        tick();
        check_idle("start_stop");

        do_reset();
        start_at(0);
        while (c < 10) tick();
        rst_n    = 1'b0;
        m_active = 1'b0;
        tick();
        check_idle("rst_settle");
        rst_n = 1'b1;
        tick();
        check_idle("after_rst");

        // Symbol table at phase 5: slicing, lock build-up, threshold and saturation edges.
        do_reset();
        cur_ei = 1'b0; cur_eq = 1'b0; cur_el = 1'b0;
        start_at(5);
        t_last = RUN_FIRST + 5 + SPS * (N_VEC - 1);
        while (c < t_last + 6) begin
            tick();
            if (c >= RUN_FIRST) begin
                idx = (c - RUN_FIRST) / SPS;
                if (idx < N_VEC) begin
                    I_filtered = tbl[idx].i;
                    Q_filtered = tbl[idx].q;
                    cur_ei     = tbl[idx].ei;
                    cur_eq     = tbl[idx].eq;
                    cur_el     = tbl[idx].el;
                end
            end
        end
        stop         = 1'b1;
        m_strobe_end = t_last + 8;
        tick();
        stop = 1'b0;
        tick();
        check("busy_stop_run", busy, 0);
        while (c < t_last + 16) tick();
        check_idle("end_table");
        check("sb_empty_table", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
